// File: rtl/clk_period_meas.sv
// clk_period_meas: measures tick_i rising-edge period in clk_i cycles, valid/ready output
module clk_period_meas #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 tick_i,
  input  logic                 clear_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sat_o,
  output logic                 overrun_o
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t               state_q;
  logic                 tick_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ev, cnt_max, res, load;
  assign ev      = tick_i & ~tick_q;
  assign cnt_max = &cnt_q;
  assign res     = (state_q == MEASURE) & en_i & ev;
  assign load    = res & (~valid_o | ready_i);
  // edge detector, arming FSM and saturating cycle counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      tick_q <= tick_i;
      if (state_q == IDLE) begin
        cnt_q   <= '0;
        state_q <= (en_i & ev) ? MEASURE : IDLE;
      end else if (!en_i) begin
        cnt_q   <= '0;
        state_q <= IDLE;
      end else begin
        cnt_q <= ev ? '0 : cnt_q + {{(CNT_WIDTH-1){1'b0}}, ~cnt_max};
      end
    end
  end
  // result register with back-to-back handshake and sticky overrun
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      period_o  <= '0;
      sat_o     <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (load) begin
        period_o <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, ~cnt_max};
        sat_o    <= cnt_max;
      end
      valid_o   <= load | (valid_o & ~ready_i);
      overrun_o <= (res & ~load) | (overrun_o & ~clear_i);
    end
  end
endmodule

// File: tb/tb_clk_period_meas.sv
// tb_clk_period_meas: directed self-checking bench for clk_period_meas
module tb_clk_period_meas;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, tick = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [31:0] period;
  logic [3:0]  period4;
  logic        valid, sat, overrun, valid4, sat4, overrun4;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  clk_period_meas #(.CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tick_i(tick), .clear_i(clear),
    .period_o(period), .valid_o(valid), .ready_i(ready), .sat_o(sat), .overrun_o(overrun)
  );

  clk_period_meas #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tick_i(tick), .clear_i(clear),
    .period_o(period4), .valid_o(valid4), .ready_i(ready), .sat_o(sat4), .overrun_o(overrun4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_ev();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_valid", valid, 0);
    chk("rst_period", period, 0);
    chk("rst_sat", sat, 0);
    chk("rst_overrun", overrun, 0);
    // 1: period 4, first edge arms only
    rst_n = 1'b1; en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_ev();
      chk("t1_valid", valid, i == 0 ? 0 : 1);
      if (i > 0) chk("t1_period", period, 4);
      cyc(1);
      chk("t1_valid_drop", valid, 0);
      cyc(2);
    end
    // 2: stall, overrun, clear, resume
    en = 1'b0; cyc(1); en = 1'b1; ready = 1'b0;
    tick_ev(); cyc(2);
    tick_ev();
    chk("t2_valid", valid, 1);
    chk("t2_period", period, 3);
    chk("t2_ovr0", overrun, 0);
    cyc(2); tick_ev(); cyc(2); tick_ev();
    chk("t2_hold_period", period, 3);
    chk("t2_hold_valid", valid, 1);
    chk("t2_ovr1", overrun, 1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("t2_clear", overrun, 0);
    chk("t2_still_valid", valid, 1);
    cyc(1);
    ready = 1'b1;
    tick_ev();
    chk("t2_resume_valid", valid, 1);
    chk("t2_resume_period", period, 3);
    chk("t2_resume_ovr", overrun, 0);
    // 3: saturation on the narrow instance
    en = 1'b0; cyc(1); en = 1'b1;
    tick_ev(); cyc(19);
    tick_ev();
    chk("t3_sat_period", period4, 15);
    chk("t3_sat_flag", sat4, 1);
    chk("t3_wide_period", period, 20);
    chk("t3_wide_sat", sat, 0);
    cyc(5);
    tick_ev();
    chk("t3_nosat_period", period4, 6);
    chk("t3_nosat_flag", sat4, 0);
    // 4: held level gives one event per rising edge
    en = 1'b0; cyc(1); en = 1'b1;
    tick = 1'b1; cyc(10);
    chk("t4_no_event_high", valid, 0);
    tick = 1'b0; cyc(5);
    tick = 1'b1; cyc(1);
    chk("t4_valid", valid, 1);
    chk("t4_period", period, 15);
    cyc(3);
    chk("t4_single_event", valid, 0);
    tick = 1'b0;
    // 5: enable drop keeps held result, re-arm needed
    en = 1'b0; cyc(1); en = 1'b1; ready = 1'b0;
    tick_ev(); cyc(4);
    tick_ev();
    chk("t5_period", period, 5);
    cyc(2);
    en = 1'b0;
    tick_ev(); cyc(2);
    chk("t5_held_valid", valid, 1);
    chk("t5_held_period", period, 5);
    chk("t5_no_ovr", overrun, 0);
    en = 1'b1; ready = 1'b1; cyc(1);
    chk("t5_accepted", valid, 0);
    tick_ev();
    chk("t5_arm_only", valid, 0);
    cyc(6);
    tick_ev();
    chk("t5_new_valid", valid, 1);
    chk("t5_new_period", period, 7);
    // 6: reset mid-period with valid held
    ready = 1'b0;
    cyc(2);
    chk("t6_pre_valid", valid, 1);
    rst_n = 1'b0; cyc(1);
    chk("t6_valid", valid, 0);
    chk("t6_period", period, 0);
    chk("t6_sat", sat, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_period4", period4, 0);
    rst_n = 1'b1; ready = 1'b1;
    tick_ev();
    chk("t6_arm_only", valid, 0);
    cyc(3);
    tick_ev();
    chk("t6_valid_after", valid, 1);
    chk("t6_period_after", period, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
